// File: rtl/delay_timer_pkg.sv
// Shared types and constants for the delay countdown timer.
package delay_timer_pkg;

  // Width of the delay register and of the serial load.
  localparam int DELAY_W = 4;

  // Width of the shifted-bit counter, enough to count DELAY_W-1.
  localparam int BIT_W = $clog2(DELAY_W);

  // Default prescaler length in clock cycles per delay step.
  localparam int DEFAULT_PERIOD = 1000;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : delay_timer_pkg

// File: rtl/delay_countdown_timer_period_tick_counter.sv
// Prescaler: counts 0..PERIOD-1 while run is high and flags the last cycle
// of each period with a one-cycle tick. clear forces the count back to 0.
module period_tick_counter #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] prescale;

  // The tick marks the final cycle of a period, so the owner can act on the
  // same edge that wraps the prescaler back to 0.
  assign tick = run && (prescale == LAST);

  // Prescaler register: wraps at PERIOD-1, so it never exceeds that value.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (reset || clear) begin
      prescale <= '0;
    end else if (run) begin
      prescale <= tick ? '0 : prescale + 1'b1;
    end
  end

endmodule : period_tick_counter

// File: rtl/delay_countdown_timer.sv
// Delay countdown timer: serially loads a 4-bit delay (MSB first) while
// shift_ena is high, counts (delay+1)*PERIOD cycles, then holds done until ack.
module delay_countdown_timer
  import delay_timer_pkg::*;
#(
  parameter int PERIOD = DEFAULT_PERIOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               shift_ena,
  input  logic               ack,
  output logic [DELAY_W-1:0] count,
  output logic               counting,
  output logic               done
);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DELAY_W - 1);

  state_t             state;
  logic [DELAY_W-1:0] delay;
  logic [BIT_W-1:0]   bitcnt;
  logic               tick;

  // The prescaler only runs in COUNT and is held at 0 everywhere else, so
  // every COUNT phase starts from a fresh period.
  period_tick_counter #(
    .PERIOD (PERIOD)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state != ST_COUNT),
    .run   (state == ST_COUNT),
    .tick  (tick)
  );

  // Moore outputs decoded from the state and delay registers only.
  assign count    = delay;
  assign counting = (state == ST_COUNT);
  assign done     = (state == ST_DONE);

  // Controller: serial load, countdown and acknowledge handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      delay  <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (shift_ena) begin
            delay  <= {{(DELAY_W-1){1'b0}}, data};
            bitcnt <= BIT_W'(1);
            state  <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (shift_ena) begin
            delay  <= {delay[DELAY_W-2:0], data};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == LAST_BIT) begin
              state <= ST_COUNT;
            end
          end else begin
            // Load strobe dropped early: discard the partial value.
            delay  <= '0;
            bitcnt <= '0;
            state  <= ST_IDLE;
          end
        end

        ST_COUNT: begin
          // Zero is checked before decrementing, so delay never wraps.
          if (tick) begin
            if (delay == '0) begin
              state <= ST_DONE;
            end else begin
              delay <= delay - 1'b1;
            end
          end
        end

        ST_DONE: begin
          // A shift_ena on the ack edge is deliberately not treated as a load.
          if (ack) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : delay_countdown_timer

// File: tb/tb_delay_countdown_timer.sv
// Directed bench for delay_countdown_timer: a PERIOD=4 instance for the
// functional sequence and a PERIOD=1000 instance for the long-period case.
module tb_delay_countdown_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A, PERIOD = 4.
  logic       reset_a, data_a, shift_ena_a, ack_a;
  logic [3:0] count_a;
  logic       counting_a, done_a;

  // Instance B, PERIOD = 1000.
  logic       reset_b, data_b, shift_ena_b, ack_b;
  logic [3:0] count_b;
  logic       counting_b, done_b;

  int errors = 0;
  int checks = 0;

  delay_countdown_timer #(.PERIOD(4)) dut_a (
    .clk       (clk),
    .reset     (reset_a),
    .data      (data_a),
    .shift_ena (shift_ena_a),
    .ack       (ack_a),
    .count     (count_a),
    .counting  (counting_a),
    .done      (done_a)
  );

  delay_countdown_timer #(.PERIOD(1000)) dut_b (
    .clk       (clk),
    .reset     (reset_b),
    .data      (data_b),
    .shift_ena (shift_ena_b),
    .ack       (ack_b),
    .count     (count_b),
    .counting  (counting_b),
    .done      (done_b)
  );

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_idle(input string tag);
    check({tag, " count"},    int'(count_a),    0);
    check({tag, " counting"}, int'(counting_a), 0);
    check({tag, " done"},     int'(done_a),     0);
  endtask

  // Shift a 4-bit value into instance A, MSB first; returns just after E3.
  task automatic load_a(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) begin
      shift_ena_a = 1'b1;
      data_a      = v[i];
      step();
    end
    shift_ena_a = 1'b0;
    data_a      = 1'b0;
  endtask

  // Follow one COUNT phase. Entered in the first COUNT cycle. When pulse_at
  // is non-negative, ack/shift_ena/data are high on the edge ending COUNT
  // cycle pulse_at and low again afterwards.
  task automatic measure_a(input string tag, input int d, input int period,
                           input int pulse_at);
    int n;
    n = 0;
    check({tag, " enter counting"}, int'(counting_a), 1);
    while (counting_a === 1'b1 && n < (d + 1) * period + 8) begin
      check({tag, " count value"}, int'(count_a), d - n / period);
      if (n == pulse_at) begin
        ack_a = 1'b1; shift_ena_a = 1'b1; data_a = 1'b1;
      end else if (n == pulse_at + 1) begin
        ack_a = 1'b0; shift_ena_a = 1'b0; data_a = 1'b0;
      end
      step();
      n++;
    end
    ack_a = 1'b0; shift_ena_a = 1'b0; data_a = 1'b0;
    check({tag, " counting cycles"}, n, (d + 1) * period);
    check({tag, " done after count"}, int'(done_a), 1);
    check({tag, " count after count"}, int'(count_a), 0);
  endtask

  initial begin
    int n;
    reset_a = 1'b1; data_a = 1'b0; shift_ena_a = 1'b0; ack_a = 1'b0;
    reset_b = 1'b1; data_b = 1'b0; shift_ena_b = 1'b0; ack_b = 1'b0;
    step();
    step();
    reset_a = 1'b0;
    reset_b = 1'b0;
    check_a_idle("reset");
    check("reset b count", int'(count_b), 0);
    check("reset b counting", int'(counting_b), 0);
    check("reset b done", int'(done_b), 0);

    // Idle for 10 cycles: nothing moves.
    for (int i = 0; i < 10; i++) begin
      step();
      check_a_idle("idle");
    end

    // Load 4'hA, count 44 cycles, reach DONE.
    load_a(4'hA);
    check("load A count", int'(count_a), 10);
    measure_a("run A", 10, 4, -1);

    // DONE holds without ack; ack releases on the next edge.
    for (int i = 0; i < 20; i++) begin
      step();
      check("done hold", int'(done_a), 1);
    end
    ack_a = 1'b1;
    shift_ena_a = 1'b1;  // ignored on the ack edge
    data_a = 1'b1;
    step();
    ack_a = 1'b0;
    shift_ena_a = 1'b0;
    data_a = 1'b0;
    check_a_idle("after ack");
    step();
    check_a_idle("idle after ack");

    // Zero delay still counts one full period.
    load_a(4'h0);
    measure_a("run 0", 0, 4, -1);
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    check_a_idle("ack after 0");

    // Abort after two bits.
    shift_ena_a = 1'b1; data_a = 1'b1;
    step();
    check("abort bit1 count", int'(count_a), 1);
    step();
    check("abort bit2 count", int'(count_a), 3);
    shift_ena_a = 1'b0; data_a = 1'b0;
    step();
    check_a_idle("abort");
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort no counting", int'(counting_a), 0);
    end
    load_a(4'h3);
    check("load 3 count", int'(count_a), 3);
    measure_a("run 3", 3, 4, -1);
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;

    // shift_ena held for 5 edges; the extra edge lands in COUNT.
    load_a(4'h7);
    check("load 7 count", int'(count_a), 7);
    shift_ena_a = 1'b1; data_a = 1'b1; ack_a = 1'b1;
    measure_a("run 7 long strobe", 7, 4, 0);
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;

    // ack/shift_ena pulse mid-count changes nothing.
    load_a(4'h2);
    measure_a("run 2 pulse", 2, 4, 5);
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;

    // Reset in COUNT once count reaches 5.
    load_a(4'h8);
    n = 0;
    while (count_a !== 4'd5 && n < 40) begin
      step();
      n++;
    end
    check("reach count 5", int'(count_a), 5);
    check("reach count 5 cycles", n, 12);
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    check_a_idle("reset in count");
    step();
    check_a_idle("idle after reset");

    // Reset in DONE.
    load_a(4'h0);
    measure_a("run 0 again", 0, 4, -1);
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    check_a_idle("reset in done");

    // PERIOD=1000, delay 1: 2000 counting cycles.
    for (int i = 3; i >= 0; i--) begin
      shift_ena_b = 1'b1;
      data_b = (i == 0);
      step();
    end
    shift_ena_b = 1'b0;
    data_b = 1'b0;
    check("b enter counting", int'(counting_b), 1);
    n = 0;
    while (counting_b === 1'b1 && n < 2100) begin
      if (n == 0 || n == 999 || n == 1000 || n == 1999)
        check("b count value", int'(count_b), (n < 1000) ? 1 : 0);
      step();
      n++;
    end
    check("b counting cycles", n, 2000);
    check("b done", int'(done_b), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_delay_countdown_timer
